music_sequencer: RTL and testbench

MUSIC_SEQUENCER -- requirements
Module: music_sequencer

---
 rtl/music_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_music_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/music_sequencer.sv
// music_sequencer: plays a song stored in an on-chip note table as a square wave.
// Each entry holds {half_period, duration}; half_period 0 is a rest, duration 0
// marks the end of the song. Define MUSIC_GAP_EN to insert a GAP_CYCLES silent
// gap after every note; without it notes are separated only by the LOAD cycle.
module music_sequencer #(
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned PERIOD_W   = 28,
  parameter int unsigned DUR_W      = 28,
  parameter int unsigned GAP_CYCLES = 2_500_000
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     play,
  input  logic                     pause,
  input  logic                     stop,
  input  logic                     loop_en,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [PERIOD_W-1:0]      wr_half_period,
  input  logic [DUR_W-1:0]         wr_duration,
  output logic                     Buzzer,
  output logic                     busy,
  output logic [$clog2(DEPTH)-1:0] note_idx,
  output logic                     done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = PERIOD_W + DUR_W;
`ifdef MUSIC_GAP_EN
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_PAUSED
`ifdef MUSIC_GAP_EN
    , S_GAP
`endif
  } state_e;

  state_e                state_q, state_d, resume_q, resume_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic [PERIOD_W-1:0]   hp_q, hp_d, tone_q, tone_d;
  logic [DUR_W-1:0]      len_q, len_d, dcnt_q, dcnt_d;
  logic                  buzz_q, buzz_d, done_q, done_d;
  logic                  play_q, pause_q, stop_q;
  logic                  play_e, pause_e, stop_e;
  logic                  pausable, advance, end_song;
  logic [EW-1:0]         mem [DEPTH];
  logic [EW-1:0]         rd_q;
  logic [PERIOD_W-1:0]   rd_hp;
  logic [DUR_W-1:0]      rd_dur;
`ifdef MUSIC_GAP_EN
  logic [GW-1:0]         gap_q, gap_d;
`endif

  assign play_e  = play  & ~play_q;
  assign pause_e = pause & ~pause_q;
  assign stop_e  = stop  & ~stop_q;
  assign rd_hp   = rd_q[EW-1:DUR_W];
  assign rd_dur  = rd_q[DUR_W-1:0];

`ifdef MUSIC_GAP_EN
  assign pausable = (state_q == S_PLAY) || (state_q == S_GAP);
`else
  assign pausable = (state_q == S_PLAY);
`endif

  // The tone phase lives in buzz_q even while paused; only PLAY makes it audible.
  assign Buzzer   = buzz_q & (state_q == S_PLAY);
  assign busy     = (state_q != S_IDLE);
  assign note_idx = idx_q;
  assign done     = done_q;

  // Note table: write port plus a registered read that prefetches the next index.
  always_ff @(posedge Clock) begin
    if (wr_en) mem[wr_addr] <= {wr_half_period, wr_duration};
    rd_q <= mem[idx_d];
  end

  // Next-state, counters and note sequencing.
  always_comb begin
    state_d  = state_q;
    resume_d = resume_q;
    idx_d    = idx_q;
    hp_d     = hp_q;
    len_d    = len_q;
    tone_d   = tone_q;
    dcnt_d   = dcnt_q;
    buzz_d   = buzz_q;
    done_d   = 1'b0;
    advance  = 1'b0;
    end_song = 1'b0;
`ifdef MUSIC_GAP_EN
    gap_d    = gap_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (play_e) begin
          state_d = S_LOAD;
          idx_d   = '0;
        end
      end
      S_LOAD: begin
        hp_d  = rd_hp;
        len_d = rd_dur;
        if (rd_dur == '0) begin
          end_song = 1'b1;
        end else begin
          state_d = S_PLAY;
          tone_d  = '0;
          dcnt_d  = '0;
          buzz_d  = 1'b0;
        end
      end
      S_PLAY: begin
        dcnt_d = dcnt_q + DUR_W'(1);
        if (hp_q == '0) begin
          buzz_d = 1'b0;
          tone_d = '0;
        end else if (tone_q == hp_q - PERIOD_W'(1)) begin
          buzz_d = ~buzz_q;
          tone_d = '0;
        end else begin
          tone_d = tone_q + PERIOD_W'(1);
        end
        if (dcnt_q == len_q - DUR_W'(1)) begin
          buzz_d = 1'b0;
          tone_d = '0;
          dcnt_d = '0;
`ifdef MUSIC_GAP_EN
          state_d = S_GAP;
          gap_d   = '0;
`else
          advance = 1'b1;
`endif
        end
      end
`ifdef MUSIC_GAP_EN
      S_GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          gap_d   = '0;
          advance = 1'b1;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
`endif
      S_PAUSED: begin
        if (play_e) state_d = resume_q;
      end
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (idx_q == AW'(DEPTH - 1)) begin
        end_song = 1'b1;
      end else begin
        state_d = S_LOAD;
        idx_d   = idx_q + AW'(1);
      end
    end

    if (end_song) begin
      done_d  = 1'b1;
      idx_d   = '0;
      state_d = loop_en ? S_LOAD : S_IDLE;
    end

    // The pausing cycle still counts as played; PAUSED resumes into whatever
    // state that cycle would have led to. A pause landing on song end is dropped.
    if (pause_e && pausable && !end_song) begin
      resume_d = state_d;
      state_d  = S_PAUSED;
    end

    if (stop_e) begin
      state_d = S_IDLE;
      idx_d   = '0;
      buzz_d  = 1'b0;
      tone_d  = '0;
      dcnt_d  = '0;
      done_d  = 1'b0;
`ifdef MUSIC_GAP_EN
      gap_d   = '0;
`endif
    end
  end

  // State, working registers and edge-detect stages.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      resume_q <= S_IDLE;
      idx_q    <= '0;
      hp_q     <= '0;
      len_q    <= '0;
      tone_q   <= '0;
      dcnt_q   <= '0;
      buzz_q   <= 1'b0;
      done_q   <= 1'b0;
      play_q   <= 1'b0;
      pause_q  <= 1'b0;
      stop_q   <= 1'b0;
`ifdef MUSIC_GAP_EN
      gap_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
      idx_q    <= idx_d;
      hp_q     <= hp_d;
      len_q    <= len_d;
      tone_q   <= tone_d;
      dcnt_q   <= dcnt_d;
      buzz_q   <= buzz_d;
      done_q   <= done_d;
      play_q   <= play;
      pause_q  <= pause;
      stop_q   <= stop;
`ifdef MUSIC_GAP_EN
      gap_q    <= gap_d;
`endif
    end
  end

endmodule

// File: tb/tb_music_sequencer.sv
// tb_music_sequencer: scoreboard bench. Expected per-cycle {Buzzer,busy,done,note_idx}
// words are generated from the note table when playback is started and compared
// on every falling edge. Works with or without MUSIC_GAP_EN.
module tb_music_sequencer;

  localparam int DEPTH = 4;
  localparam int GAPC  = 2;
`ifdef MUSIC_GAP_EN
  localparam int GAPN = GAPC;
`else
  localparam int GAPN = 0;
`endif

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       play = 1'b0, pause = 1'b0, stop = 1'b0, loop_en = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [7:0] wr_half_period = '0;
  logic [7:0] wr_duration = '0;
  logic       Buzzer, busy, done;
  logic [1:0] note_idx;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [4:0]  exp_q[$];
  int          hp_m[DEPTH];
  int          dur_m[DEPTH];
  string       tname = "none";
  int          n1;

  music_sequencer #(
    .DEPTH(4),
    .PERIOD_W(8),
    .DUR_W(8),
    .GAP_CYCLES(GAPC)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .play(play),
    .pause(pause),
    .stop(stop),
    .loop_en(loop_en),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_half_period(wr_half_period),
    .wr_duration(wr_duration),
    .Buzzer(Buzzer),
    .busy(busy),
    .note_idx(note_idx),
    .done(done)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] pk(input logic b, input logic bs, input logic d, input logic [1:0] i);
    return {b, bs, d, i};
  endfunction

  // Expected trace of one pass through the table: LOAD, note cycles, gap, ...
  task automatic push_song(input logic first_done, input logic loop);
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back(pk(1'b0, 1'b1, (i == 0) && first_done, 2'(i)));
      if (dur_m[i] == 0) break;
      for (int c = 0; c < dur_m[i]; c++)
        exp_q.push_back(pk((hp_m[i] == 0) ? 1'b0 : 1'((c / hp_m[i]) % 2), 1'b1, 1'b0, 2'(i)));
      for (int g = 0; g < GAPN; g++)
        exp_q.push_back(pk(1'b0, 1'b1, 1'b0, 2'(i)));
    end
    if (!loop) begin
      exp_q.push_back(pk(1'b0, 1'b0, 1'b1, 2'd0));
      exp_q.push_back(pk(1'b0, 1'b0, 1'b0, 2'd0));
    end
  endtask

  task automatic push_idle(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(pk(1'b0, 1'b0, 1'b0, 2'd0));
  endtask

  // Advance n cycles: drop one-cycle pulses, then compare one scoreboard entry.
  task automatic run(input int n);
    logic [4:0] e;
    for (int k = 0; k < n; k++) begin
      @(negedge Clock);
      play  = 1'b0;
      pause = 1'b0;
      stop  = 1'b0;
      wr_en = 1'b0;
      if (exp_q.size() == 0) begin
        check("queue_empty", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("%s[%0d]", tname, k), 32'({Buzzer, busy, done, note_idx}), 32'(e));
      end
    end
  endtask

  task automatic wr(input int a, input int hp, input int d);
    @(negedge Clock);
    wr_en = 1'b1;
    wr_addr = 2'(a);
    wr_half_period = 8'(hp);
    wr_duration = 8'(d);
    hp_m[a] = hp;
    dur_m[a] = d;
    @(negedge Clock);
    wr_en = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge Clock);
    check("rst_buzzer", 32'(Buzzer), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_idx", 32'(note_idx), 32'd0);
    Reset = 1'b0;

    wr(0, 3, 12); wr(1, 0, 5); wr(2, 1, 4); wr(3, 7, 0);

    tname = "basic";
    push_song(1'b0, 1'b0);
    play = 1'b1;
    run(exp_q.size());

    // Pause after note-0 cycle 5, hold 20 cycles, resume.
    tname = "pause";
    push_song(1'b0, 1'b0);
    for (int k = 0; k < 20; k++) exp_q.insert(7, pk(1'b0, 1'b1, 1'b0, 2'd0));
    play = 1'b1;
    run(7);
    pause = 1'b1;
    run(20);
    play = 1'b1;
    run(exp_q.size());

    tname = "loop";
    loop_en = 1'b1;
    push_song(1'b0, 1'b1);
    n1 = exp_q.size();
    push_song(1'b1, 1'b1);
    play = 1'b1;
    run(n1 + 7);
    stop = 1'b1;
    exp_q.delete();
    push_idle(4);
    run(4);
    loop_en = 1'b0;

    tname = "simul";
    push_song(1'b0, 1'b0);
    play = 1'b1;
    run(4);
    exp_q.delete();
    push_idle(3);
    stop = 1'b1; pause = 1'b1; play = 1'b1;
    run(3);

    tname = "rst_gap";
    push_song(1'b0, 1'b0);
    play = 1'b1;
    run(1 + 12 + 1);
    exp_q.delete();
    #2 Reset = 1'b1;
    #1;
    check("async_buzzer", 32'(Buzzer), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_done", 32'(done), 32'd0);
    check("async_idx", 32'(note_idx), 32'd0);
    @(negedge Clock);
    Reset = 1'b0;

    // Table contents survive reset.
    tname = "after_rst";
    push_song(1'b0, 1'b0);
    play = 1'b1;
    run(exp_q.size());

    wr(0, 2, 3); wr(1, 1, 2); wr(2, 0, 2); wr(3, 3, 4);
    tname = "full";
    push_song(1'b0, 1'b0);
    play = 1'b1;
    run(exp_q.size());

    // Rewrite entry 0 while it plays; change shows only on the looped replay.
    wr(0, 3, 12); wr(1, 0, 2); wr(2, 1, 2); wr(3, 0, 0);
    tname = "wr_live";
    loop_en = 1'b1;
    push_song(1'b0, 1'b1);
    n1 = exp_q.size();
    hp_m[0] = 1;
    dur_m[0] = 6;
    push_song(1'b1, 1'b1);
    play = 1'b1;
    run(5);
    wr_en = 1'b1; wr_addr = 2'd0; wr_half_period = 8'd1; wr_duration = 8'd6;
    run(n1 - 5 + 1 + 8);
    stop = 1'b1;
    exp_q.delete();
    push_idle(2);
    run(2);
    loop_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
